// File: rtl/player_input_frontend_if.sv
// Commit channel from the input frontend to the game controller.
// The master presents {bet, parity} under valid; the slave accepts it with ready.
interface player_input_frontend_if;
    logic       commit_valid;
    logic [4:0] commit_bet;
    logic       commit_parity;
    logic       commit_ready;

    modport master (
        output commit_valid,
        output commit_bet,
        output commit_parity,
        input  commit_ready
    );

    modport slave (
        input  commit_valid,
        input  commit_bet,
        input  commit_parity,
        output commit_ready
    );
endinterface

// File: rtl/player_input_frontend.sv
// Player-input producer: synchronises and debounces the buttons, clamps the bet
// against the active player's marble count and offers each save as a commit.
//
// state        | meaning
// IDLE         | button released and stable
// PRESS_WAIT   | synchronised input high, counting towards acceptance
// HELD         | press accepted (pulse emitted on entry), waiting for release
// RELEASE_WAIT | synchronised input low, counting towards accepted release
module player_input_frontend #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       save_btn,
    input  logic       restart_btn,
    input  logic       bet_sw,
    input  logic [3:0] bet_num,
    input  logic [4:0] max_bet,
    output logic       save_pulse,
    output logic       restart_pulse,
    output logic [4:0] bet_live,
    output logic       drop_flag,
    player_input_frontend_if.master commit
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } deb_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] save_sync;
    logic [1:0] restart_sync;
    logic [1:0] sw_sync;
    logic [3:0] num_meta;
    logic [3:0] num_sync;
    logic [1:0] btn_s;

    deb_state_t       state_q [2];
    deb_state_t       state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic [1:0]       pulse_d;
    logic [1:0]       pulse_q;

    logic [4:0] clamp_bet;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            save_sync    <= '0;
            restart_sync <= '0;
            sw_sync      <= '0;
            num_meta     <= '0;
            num_sync     <= '0;
        end else begin
            save_sync    <= {save_sync[0], save_btn};
            restart_sync <= {restart_sync[0], restart_btn};
            sw_sync      <= {sw_sync[0], bet_sw};
            num_meta     <= bet_num;
            num_sync     <= num_meta;
        end
    end

    // index 0 = save, index 1 = restart
    assign btn_s = {restart_sync[1], save_sync[1]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (btn_s[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = HELD;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_s[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s[i]) begin
                        state_d[i] = HELD;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    assign save_pulse    = pulse_q[0];
    assign restart_pulse = pulse_q[1];

    // max_bet comes from the controller on this clock, so it is used directly
    always_comb begin
        clamp_bet = {1'b0, num_sync};
        if (max_bet == 5'd0) begin
            clamp_bet = 5'd0;
        end else if (num_sync == 4'd0) begin
            clamp_bet = 5'd1;
        end else if ({1'b0, num_sync} > max_bet) begin
            clamp_bet = max_bet;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bet_live <= '0;
        end else begin
            bet_live <= clamp_bet;
        end
    end

    // Restart beats everything; a save while stalled only raises drop_flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            commit.commit_valid  <= 1'b0;
            commit.commit_bet    <= '0;
            commit.commit_parity <= 1'b0;
            drop_flag            <= 1'b0;
        end else if (restart_pulse) begin
            commit.commit_valid <= 1'b0;
            drop_flag           <= 1'b0;
        end else if (save_pulse && (!commit.commit_valid || commit.commit_ready)) begin
            commit.commit_valid  <= 1'b1;
            commit.commit_bet    <= bet_live;
            commit.commit_parity <= sw_sync[1];
        end else if (save_pulse) begin
            drop_flag <= 1'b1;
        end else if (commit.commit_valid && commit.commit_ready) begin
            commit.commit_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_player_input_frontend.sv
// Scoreboard bench for player_input_frontend: stimulus pushes expected pulses
// and commits into queues, a negedge monitor pops and compares them.
module tb_player_input_frontend;
    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       save_btn = 1'b0;
    logic       restart_btn = 1'b0;
    logic       bet_sw = 1'b0;
    logic [3:0] bet_num = 4'd0;
    logic [4:0] max_bet = 5'd0;
    logic       save_pulse;
    logic       restart_pulse;
    logic [4:0] bet_live;
    logic       drop_flag;

    player_input_frontend_if cif ();

    player_input_frontend #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .save_btn      (save_btn),
        .restart_btn   (restart_btn),
        .bet_sw        (bet_sw),
        .bet_num       (bet_num),
        .max_bet       (max_bet),
        .save_pulse    (save_pulse),
        .restart_pulse (restart_pulse),
        .bet_live      (bet_live),
        .drop_flag     (drop_flag),
        .commit        (cif)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int bet;
        int par;
    } commit_t;

    int      total = 0;
    int      bad = 0;
    int      exp_save[$];
    int      exp_restart[$];
    commit_t exp_commit[$];
    bit      model_pending = 0;
    bit      model_drop = 0;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(string name);
        total++;
        bad++;
        $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
    endtask

    function automatic int clamp_ref(int b, int m);
        if (m == 0) return 0;
        if (b == 0) return 1;
        if (b > m) return m;
        return b;
    endfunction

    // Monitor
    logic       prev_valid = 1'b0;
    logic       prev_hs = 1'b0;
    logic [4:0] prev_bet = 5'd0;
    logic       prev_par = 1'b0;
    commit_t    got;

    always @(negedge clock) begin
        if (save_pulse === 1'b1) begin
            if (exp_save.size() == 0) unexpected("save_pulse");
            else check("save_pulse_cycle", cyc, exp_save.pop_front());
        end
        if (restart_pulse === 1'b1) begin
            if (exp_restart.size() == 0) unexpected("restart_pulse");
            else check("restart_pulse_cycle", cyc, exp_restart.pop_front());
        end
        if (cif.commit_valid && prev_valid && !prev_hs && reset) begin
            check("commit_bet_hold", int'(cif.commit_bet), int'(prev_bet));
            check("commit_parity_hold", int'(cif.commit_parity), int'(prev_par));
        end
        if (cif.commit_valid === 1'b1 && cif.commit_ready === 1'b1) begin
            if (exp_commit.size() == 0) begin
                unexpected("commit_transfer");
            end else begin
                got = exp_commit.pop_front();
                check("commit_bet", int'(cif.commit_bet), got.bet);
                check("commit_parity", int'(cif.commit_parity), got.par);
            end
        end
        prev_valid <= cif.commit_valid;
        prev_hs    <= cif.commit_valid & cif.commit_ready;
        prev_bet   <= cif.commit_bet;
        prev_par   <= cif.commit_parity;
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_save_pulse"}, int'(save_pulse), 0);
        check({tag, "_restart_pulse"}, int'(restart_pulse), 0);
        check({tag, "_bet_live"}, int'(bet_live), 0);
        check({tag, "_commit_valid"}, int'(cif.commit_valid), 0);
        check({tag, "_commit_bet"}, int'(cif.commit_bet), 0);
        check({tag, "_commit_parity"}, int'(cif.commit_parity), 0);
        check({tag, "_drop_flag"}, int'(drop_flag), 0);
    endtask

    // Hold the button(s) for 'hold' cycles then release long enough to settle.
    task automatic press(bit s, bit r, int hold);
        int      t;
        commit_t c;
        c.bet = clamp_ref(int'(bet_num), int'(max_bet));
        c.par = int'(bet_sw);
        save_btn    = s;
        restart_btn = r;
        t = cyc + 1;
        if (hold >= D + 2) begin
            if (s) exp_save.push_back(t + 2 + D);
            if (r) exp_restart.push_back(t + 2 + D);
        end
        step(hold);
        save_btn    = 1'b0;
        restart_btn = 1'b0;
        step(D + 4);
        if (hold >= D + 2) begin
            if (r) begin
                if (model_pending) void'(exp_commit.pop_back());
                model_pending = 0;
                model_drop    = 0;
            end else if (s) begin
                if (model_pending) model_drop = 1;
                else begin
                    exp_commit.push_back(c);
                    model_pending = 1;
                end
            end
        end
        check("commit_valid_after_press", int'(cif.commit_valid), int'(model_pending));
        check("drop_flag_after_press", int'(drop_flag), int'(model_drop));
    endtask

    task automatic pulse_ready();
        cif.commit_ready = 1'b1;
        step(1);
        cif.commit_ready = 1'b0;
        model_pending = 0;
        check("commit_valid_after_ready", int'(cif.commit_valid), 0);
        step(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int clamp_bn [4] = '{9, 0, 7, 3};
    int clamp_mb [4] = '{6, 6, 0, 10};
    int clamp_ex [4] = '{6, 1, 0, 3};
    int t_rel;

    initial begin
        cif.commit_ready = 1'b0;
        step(3);
        check_all_zero("reset");
        reset = 1'b1;
        step(2);

        for (int i = 0; i < 4; i++) begin
            bet_num = 4'(clamp_bn[i]);
            max_bet = 5'(clamp_mb[i]);
            step(4);
            check("bet_live_table", int'(bet_live), clamp_ex[i]);
        end

        // long hold then a commit stalled by ready=0
        bet_num = 4'd5; bet_sw = 1'b1; max_bet = 5'd10;
        step(4);
        press(1, 0, 20);
        check("commit_bet_first", int'(cif.commit_bet), 5);
        check("commit_parity_first", int'(cif.commit_parity), 1);
        press(1, 0, 3);
        bet_num = 4'd2; bet_sw = 1'b0;
        step(4);
        press(1, 0, D + 2);
        check("commit_bet_after_drop", int'(cif.commit_bet), 5);
        press(0, 1, D + 2);

        press(1, 0, D + 3);
        max_bet = 5'd1;
        step(2);
        pulse_ready();
        pulse_ready();

        max_bet = 5'd10;
        step(2);
        press(1, 0, D + 2);
        press(1, 1, D + 3);
        press(1, 1, D + 2);

        for (int i = 0; i < 12; i++) begin
            bet_num = 4'($urandom_range(0, 15));
            bet_sw  = 1'($urandom_range(0, 1));
            max_bet = 5'($urandom_range(0, 31));
            step(4);
            check("bet_live_rand", int'(bet_live), clamp_ref(int'(bet_num), int'(max_bet)));
            case ($urandom_range(0, 4))
                0, 1: press(1, 0, $urandom_range(D + 2, 2 * D + 4));
                2: pulse_ready();
                3: press(1, 0, $urandom_range(1, D - 1));
                default: press(0, 1, D + 2);
            endcase
        end
        if (model_pending) pulse_ready();

        // reset mid-handshake and mid-PRESS_WAIT with save still held
        bet_num = 4'd7; bet_sw = 1'b1; max_bet = 5'd12;
        step(4);
        press(1, 0, D + 2);
        save_btn = 1'b1;
        step(3);
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid");
        exp_commit.delete();
        model_pending = 0;
        model_drop    = 0;
        step(3);
        reset = 1'b1;
        t_rel = cyc + 1;
        exp_save.push_back(t_rel + 2 + D);
        exp_commit.push_back('{7, 1});
        model_pending = 1;
        step(D + 8);
        save_btn = 1'b0;
        step(D + 4);
        check("commit_valid_after_reset_press", int'(cif.commit_valid), 1);
        pulse_ready();

        step(4);
        check("queues_drained", exp_save.size() + exp_restart.size() + exp_commit.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/player_input_frontend.md
Name: player_input_frontend

Overview:
- Producer side of the player-input interface that the game controller consumes.
- Synchronises and debounces the save and restart buttons, then emits single-cycle press pulses.
- Samples the bet switches and clamps the bet against the active player's marble count.
- On each save press, presents a {bet, parity} commit to the game controller over a valid/ready handshake, so the controller no longer needs its own edge detection or slow-tick sampling.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronised cycles required to accept a level change (5 ms at 50 MHz).
- CNT_W, 18: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- save_btn  in  1  raw save button, high = pressed
- restart_btn  in  1  raw restart button, high = pressed
- bet_sw  in  1  raw parity switch: 0 = odd, 1 = even
- bet_num  in  4  raw bet switches, 0..15
- max_bet  in  5  active player's marble count, driven by the game controller
- save_pulse  out  1  one-cycle pulse per debounced save press
- restart_pulse  out  1  one-cycle pulse per debounced restart press
- bet_live  out  5  continuously clamped bet, for the hex display
- commit_valid  out  1  a commit is pending
- commit_bet  out  5  latched clamped bet
- commit_parity  out  1  latched parity
- commit_ready  in  1  game controller accepts the commit
- drop_flag  out  1  sticky: a save press arrived while a commit was pending

Behaviour:
- Reset (reset low, asynchronous): every output and every internal register goes to 0; debounce FSMs go to IDLE.
- Synchronisation: all raw inputs pass through 2-flop synchronisers. bet_num and bet_sw are synchronised only, not debounced.
- Debounce FSM, one instance per button. States: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: sync=1 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT: sync=0 -> IDLE. Counter reaches DEBOUNCE_CYCLES-1 with sync=1 -> HELD and the pulse fires for exactly one cycle.
  - HELD: sync=0 -> RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: sync=1 -> HELD with no pulse. Counter reaches DEBOUNCE_CYCLES-1 with sync=0 -> IDLE.
- Press latency: raw rising at cycle t gives the pulse at cycle t+2+DEBOUNCE_CYCLES, provided the input stays stable.
- One pulse per press; holding a button never repeats the pulse.
- Clamp (combinational on synchronised values), in priority order:
  - max_bet==0 -> 0
  - bet_num==0 -> 1
  - bet_num>max_bet -> max_bet
  - otherwise bet_num, zero-extended to 5 bits
- bet_live is the clamp output, registered with 1-cycle latency.
- Commit handshake:
  - save_pulse with commit_valid=0: next cycle commit_valid=1, commit_bet=bet_live, commit_parity=synchronised bet_sw.
  - commit_bet and commit_parity stay stable while commit_valid=1.
  - commit_valid=1 and commit_ready=1 in a cycle: transfer completes and commit_valid=0 next cycle.
  - commit_ready is ignored while commit_valid=0.
- Simultaneous events:
  - save_pulse in the same cycle as an accepted commit (valid & ready): the new commit loads and commit_valid stays 1.
  - save_pulse with valid=1 and ready=0: press discarded, drop_flag=1 next cycle.
  - restart_pulse: next cycle commit_valid=0 and drop_flag=0. Restart wins over a same-cycle save_pulse, whose commit is discarded.
  - save_pulse and restart_pulse are themselves still emitted in all of these cases.
- max_bet changing while a commit is pending does not alter commit_bet.
- Reset asserted mid-debounce or mid-handshake: immediate clear. After release, a button held through reset must pass the full PRESS_WAIT before pulsing.

Test Plan:
- DEBOUNCE_CYCLES=4; raw save rises at cycle 10 and stays high -> single save_pulse at cycle 16, none while held; release then re-press -> second pulse.
- Save glitch high for 3 cycles -> no pulse; FSM returns to IDLE.
- bet_num=9, max_bet=6 -> bet_live=6. bet_num=0, max_bet=6 -> 1. max_bet=0 -> 0. bet_num=3, max_bet=10 -> 3.
- Save press with bet_num=5, bet_sw=1, max_bet=10, commit_ready=0 -> commit_valid=1, commit_bet=5, commit_parity=1, held; commit_ready pulsed -> commit_valid=0 the next cycle.
- Commit pending, ready=0, second save press -> commit_bet unchanged, drop_flag=1; restart press -> commit_valid=0, drop_flag=0.
- Reset driven low mid-PRESS_WAIT with save held -> all outputs 0 immediately; after release, pulse occurs DEBOUNCE_CYCLES+2 cycles later, not earlier.
